// File: rtl/video_mode_ctrl.sv
// Video mode sequencer: owns the timing parameter set for the video timing generator and
// applies mode changes only at a frame boundary, holding the generator in reset and blanking output.
module video_mode_ctrl #(
  parameter int unsigned DEFAULT_MODE = 2,
  parameter int unsigned RST_CYCLES   = 16,
  parameter int unsigned BLANK_FRAMES = 2,
  parameter int unsigned TIMEOUT      = 2_000_000
) (
  input  logic        I_clk,
  input  logic        I_rst_n,
  input  logic        I_req,
  input  logic [1:0]  I_mode_sel,
  input  logic        I_vs,
  output logic        O_busy,
  output logic        O_ack,
  output logic        O_err,
  output logic [1:0]  O_mode_cur,
  output logic        O_tg_rst_n,
  output logic        O_blank,
  output logic [11:0] O_h_total,
  output logic [11:0] O_h_sync,
  output logic [11:0] O_h_bporch,
  output logic [11:0] O_h_res,
  output logic [11:0] O_v_total,
  output logic [11:0] O_v_sync,
  output logic [11:0] O_v_bporch,
  output logic [11:0] O_v_res,
  output logic        O_hs_pol,
  output logic        O_vs_pol,
  output logic [1:0]  O_dbg_state
);

  // Handshake: I_req is a level sampled only in IDLE; acceptance shows as O_busy=1 the next
  // cycle, completion as a one-cycle O_ack, rejection (mode 3) as a one-cycle O_err.

  localparam int HCW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam int FCW = $clog2(BLANK_FRAMES + 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WAIT   = 2'd1,
    S_HOLD   = 2'd2,
    S_SETTLE = 2'd3
  } state_t;

  typedef struct packed {
    logic [11:0] h_total;
    logic [11:0] h_sync;
    logic [11:0] h_bp;
    logic [11:0] h_res;
    logic [11:0] v_total;
    logic [11:0] v_sync;
    logic [11:0] v_bp;
    logic [11:0] v_res;
    logic        hs_pol;
    logic        vs_pol;
  } timing_t;

  function automatic timing_t mode_table(input logic [1:0] m);
    timing_t t;
    case (m)
      2'd0:    t = '{12'd1056, 12'd128, 12'd88,  12'd800,  12'd628, 12'd4, 12'd23, 12'd600, 1'b1, 1'b1};
      2'd1:    t = '{12'd1344, 12'd136, 12'd160, 12'd1024, 12'd806, 12'd6, 12'd29, 12'd768, 1'b0, 1'b0};
      default: t = '{12'd1650, 12'd40,  12'd220, 12'd1280, 12'd750, 12'd5, 12'd20, 12'd720, 1'b1, 1'b1};
    endcase
    return t;
  endfunction

  localparam timing_t DEF_T = mode_table(2'(DEFAULT_MODE));

  state_t      r_state;
  state_t      w_state_nxt;
  timing_t     r_timing;
  logic [1:0]  r_mode_cur;
  logic [1:0]  r_pend;
  logic        r_vs_q;
  logic [21:0] r_tmo;
  logic [HCW-1:0] r_hold_cnt;
  logic [FCW-1:0] r_frames;
  logic        r_boot;
  logic        r_busy;
  logic        r_ack;
  logic        r_err;
  logic        r_tg_rst_n;
  logic        r_blank;

  logic w_vs_end;
  logic w_tmo_hit;
  logic w_hold_done;
  logic w_settle_done;
  logic w_busy_nxt;
  logic w_ack_nxt;
  logic w_err_nxt;
  logic w_tg_rst_n_nxt;
  logic w_blank_nxt;
  logic w_load;
  logic w_accept;

  // End of VS: previous sample active, current sample inactive, using the applied polarity.
  assign w_vs_end      = (r_vs_q == r_timing.vs_pol) && (I_vs != r_timing.vs_pol);
  assign w_tmo_hit     = (r_tmo == 22'(TIMEOUT - 1));
  assign w_hold_done   = (r_hold_cnt == HCW'(RST_CYCLES - 1));
  assign w_settle_done = (w_vs_end && (r_frames == FCW'(BLANK_FRAMES - 1))) || w_tmo_hit;

  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) r_state <= S_HOLD;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (I_req && (I_mode_sel != 2'd3)) w_state_nxt = S_WAIT;
      S_WAIT:   if (w_vs_end || w_tmo_hit)         w_state_nxt = S_HOLD;
      S_HOLD:   if (w_hold_done)                   w_state_nxt = S_SETTLE;
      S_SETTLE: if (w_settle_done)                 w_state_nxt = S_IDLE;
      default:                                     w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_busy_nxt     = r_busy;
    w_ack_nxt      = 1'b0;
    w_err_nxt      = 1'b0;
    w_tg_rst_n_nxt = r_tg_rst_n;
    w_blank_nxt    = r_blank;
    w_load         = 1'b0;
    w_accept       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (I_req) begin
          if (I_mode_sel == 2'd3) begin
            w_err_nxt = 1'b1;
          end else begin
            w_accept   = 1'b1;
            w_busy_nxt = 1'b1;
          end
        end
      end
      S_WAIT: begin
        if (w_vs_end || w_tmo_hit) begin
          w_load         = 1'b1;
          w_tg_rst_n_nxt = 1'b0;
          w_blank_nxt    = 1'b1;
        end
      end
      S_HOLD: begin
        if (w_hold_done) w_tg_rst_n_nxt = 1'b1;
      end
      S_SETTLE: begin
        if (w_settle_done) begin
          w_blank_nxt = 1'b0;
          w_busy_nxt  = 1'b0;
          w_ack_nxt   = ~r_boot;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      r_timing   <= DEF_T;
      r_mode_cur <= 2'(DEFAULT_MODE);
      r_pend     <= 2'(DEFAULT_MODE);
      r_vs_q     <= ~DEF_T.vs_pol;
      r_tmo      <= '0;
      r_hold_cnt <= '0;
      r_frames   <= '0;
      r_boot     <= 1'b1;
      r_busy     <= 1'b0;
      r_ack      <= 1'b0;
      r_err      <= 1'b0;
      r_tg_rst_n <= 1'b0;
      r_blank    <= 1'b1;
    end else begin
      r_vs_q     <= I_vs;
      r_busy     <= w_busy_nxt;
      r_ack      <= w_ack_nxt;
      r_err      <= w_err_nxt;
      r_tg_rst_n <= w_tg_rst_n_nxt;
      r_blank    <= w_blank_nxt;
      if (w_accept) r_pend <= I_mode_sel;
      if (w_load) begin
        r_timing   <= mode_table(r_pend);
        r_mode_cur <= r_pend;
      end
      if ((w_state_nxt != r_state) || w_vs_end) r_tmo <= '0;
      else if (r_tmo != '1)                     r_tmo <= r_tmo + 22'd1;
      if (r_state != S_HOLD) r_hold_cnt <= '0;
      else                   r_hold_cnt <= r_hold_cnt + HCW'(1);
      if (r_state != S_SETTLE) r_frames <= '0;
      else if (w_vs_end)       r_frames <= r_frames + FCW'(1);
      if ((r_state == S_SETTLE) && w_settle_done) r_boot <= 1'b0;
    end
  end

  assign O_busy      = r_busy;
  assign O_ack       = r_ack;
  assign O_err       = r_err;
  assign O_mode_cur  = r_mode_cur;
  assign O_tg_rst_n  = r_tg_rst_n;
  assign O_blank     = r_blank;
  assign O_h_total   = r_timing.h_total;
  assign O_h_sync    = r_timing.h_sync;
  assign O_h_bporch  = r_timing.h_bp;
  assign O_h_res     = r_timing.h_res;
  assign O_v_total   = r_timing.v_total;
  assign O_v_sync    = r_timing.v_sync;
  assign O_v_bporch  = r_timing.v_bp;
  assign O_v_res     = r_timing.v_res;
  assign O_hs_pol    = r_timing.hs_pol;
  assign O_vs_pol    = r_timing.vs_pol;
  assign O_dbg_state = r_state;

endmodule
